// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one write port and one read port of a small register memory between
// two requesters. At most one transaction (read or write) is granted per
// cycle. Arbitration is round-robin. A requester may hold the grant across
// an atomic sequence with req_lock. The lock is force-released after
// MAX_LOCK consecutive accepted transactions so the other side cannot starve.
module mem_port_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_lock,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  w_en,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [DATA_W-1:0]     w_data,
    output logic [ADDR_W-1:0]     r_addr,
    input  logic [DATA_W-1:0]     r_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // lock_cnt counts transactions already done under the current lock.
    // Once it reaches MAX_LOCK-1, the next accept is the last one allowed,
    // so the owner gets at most MAX_LOCK grants in a row.
    localparam logic [3:0] LOCK_LAST    = 4'(MAX_LOCK - 1);
    localparam bit         LOCK_ALLOWED = (MAX_LOCK > 1);

    logic [1:0]        state;
    logic              prio;
    logic [3:0]        lock_cnt;
    logic [1:0]        grant;
    logic              acc;
    logic              sel;
    logic              acc_we;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Combinational grant: round-robin when idle, owner-only when locked
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid == 2'b11) begin
                        grant = prio ? 2'b10 : 2'b01;
                    end else begin
                        grant = req_valid;
                    end
                end
                ST_LOCK0: grant = {1'b0, req_valid[0]};
                ST_LOCK1: grant = {req_valid[1], 1'b0};
                default:  grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign acc       = |grant;
    assign sel       = grant[1];
    assign acc_we    = req_we[sel];
    assign acc_lock  = req_lock[sel];
    assign acc_addr  = sel ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    assign acc_wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

    // Memory port drive: zero on every field that is not in use this cycle
    always_comb begin
        w_en   = acc & acc_we;
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        if (acc && acc_we) begin
            w_addr = acc_addr;
            w_data = acc_wdata;
        end
        if (acc && !acc_we) begin
            r_addr = acc_addr;
        end
    end

    // Arbitration state: lock ownership, lock count and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            prio     <= 1'b0;
            lock_cnt <= 4'd0;
        end else if (acc) begin
            if (state == ST_IDLE) begin
                if (acc_lock && LOCK_ALLOWED) begin
                    state    <= sel ? ST_LOCK1 : ST_LOCK0;
                    lock_cnt <= 4'd1;
                end else begin
                    prio <= ~sel;
                end
            end else begin
                if (acc_lock && (lock_cnt < LOCK_LAST)) begin
                    lock_cnt <= lock_cnt + 4'd1;
                end else begin
                    state    <= ST_IDLE;
                    prio     <= ~sel;
                    lock_cnt <= 4'd0;
                end
            end
        end
    end

    // Read response capture: one-cycle pulse, data held until the next read
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (acc && !acc_we) begin
                rsp_valid <= grant;
                if (sel) begin
                    rsp_data[DATA_W +: DATA_W] <= r_data;
                end else begin
                    rsp_data[0 +: DATA_W] <= r_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for the two-requester memory arbiter. A small register
// memory sits behind the arbiter. Each task drives one scenario and checks
// the expected grant, port and response values it has worked out by hand.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic [2:0]  r_addr;
    logic [15:0] r_data;

    int errors;
    int checks;

    logic [15:0] mem [0:7];

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(3), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .r_addr    (r_addr),
        .r_data    (r_data)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i resets to 16'h1000+i, writes land on posedge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end
    assign r_data = mem[r_addr];

    // Stimulus helper: puts one request vector on the inputs
    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    // Reset holds off grants and writes, then requester 0 wins first
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(2'b11, 2'b11, 2'b00, 3'd1, 3'd2, 16'h1111, 16'h2222);
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_ready: got=%b want=00", req_ready);
            end
            checks++;
            if (w_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_wen: got=%b want=0", w_en);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_rsp_valid: got=%b want=00", rsp_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got=%b want=01", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_first_rsp: got=%b want=01", rsp_valid);
        end
    endtask

    // Write then read back the same word from requester 0
    task automatic test_write_read();
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 16'hBEEF, 16'h0);
        #1;
        checks++;
        if ({req_ready, w_en, w_addr, w_data, r_addr} !== {2'b01, 1'b1, 3'd3, 16'hBEEF, 3'd0}) begin
            errors++;
            $display("[TB] FAIL wr_port: ready=%b wen=%b waddr=%0d wdata=%h raddr=%0d want 01 1 3 beef 0",
                     req_ready, w_en, w_addr, w_data, r_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 16'h0, 16'h0);
        #1;
        checks++;
        if ({req_ready, w_en, w_addr, w_data, r_addr} !== {2'b01, 1'b0, 3'd0, 16'h0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL rd_port: ready=%b wen=%b waddr=%0d wdata=%h raddr=%0d want 01 0 0 0000 3",
                     req_ready, w_en, w_addr, w_data, r_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_data[15:0] !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL rd_rsp: valid=%b data=%h want 01 beef", rsp_valid, rsp_data[15:0]);
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data[15:0] !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL rd_rsp_hold: valid=%b data=%h want 00 beef", rsp_valid, rsp_data[15:0]);
        end
    endtask

    // Single write from requester 1 moves the pointer back to requester 0
    task automatic test_single_toggle();
        @(negedge clk);
        drive(2'b10, 2'b10, 2'b00, 3'd0, 3'd5, 16'h0, 16'h5555);
        #1;
        checks++;
        if ({req_ready, w_en, w_addr, w_data} !== {2'b10, 1'b1, 3'd5, 16'h5555}) begin
            errors++;
            $display("[TB] FAIL single_req1_wr: ready=%b wen=%b waddr=%0d wdata=%h want 10 1 5 5555",
                     req_ready, w_en, w_addr, w_data);
        end
        @(posedge clk); #1;
    endtask

    // Both requesters read continuously: grants alternate 01,10,01,10
    task automatic test_round_robin();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            drive(2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 16'h0, 16'h0);
            #1;
            checks++;
            if (req_ready !== exp) begin
                errors++;
                $display("[TB] FAIL rr_ready[%0d]: got=%b want=%b", i, req_ready, exp);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== exp) begin
                errors++;
                $display("[TB] FAIL rr_rsp_valid[%0d]: got=%b want=%b", i, rsp_valid, exp);
            end
            checks++;
            if (exp[0] ? (rsp_data[15:0] !== 16'h1001) : (rsp_data[31:16] !== 16'h1002)) begin
                errors++;
                $display("[TB] FAIL rr_rsp_data[%0d]: got=%h want=%h", i,
                         exp[0] ? rsp_data[15:0] : rsp_data[31:16], exp[0] ? 16'h1001 : 16'h1002);
            end
        end
    endtask

    // Requester 1 holds the lock for 3 writes plus a closing unlocked write
    task automatic test_lock();
        logic [1:0] exp;
        logic [1:0] lk;
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL lock_pre: got=%b want=01", req_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            exp = (i < 4) ? 2'b10 : 2'b01;
            lk  = (i < 3) ? 2'b10 : 2'b00;
            @(negedge clk);
            drive(2'b11, 2'b10, lk, 3'd0, 3'(4 + (i % 2)), 16'h0, 16'hA000 + 16'(i));
            #1;
            checks++;
            if (req_ready !== exp) begin
                errors++;
                $display("[TB] FAIL lock_ready[%0d]: got=%b want=%b", i, req_ready, exp);
            end
            checks++;
            if (w_en !== exp[1] || (exp[1] && w_data !== 16'hA000 + 16'(i))) begin
                errors++;
                $display("[TB] FAIL lock_write[%0d]: wen=%b wdata=%h want %b %h", i, w_en, w_data,
                         exp[1], 16'hA000 + 16'(i));
            end
            @(posedge clk); #1;
        end
    endtask

    // Requester 1 never drops the lock: 4 grants, one to 0, then re-lock
    task automatic test_lock_timeout();
        logic [1:0] exp_seq [9];
        logic [1:0] lk;
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 9; i++) begin
            lk = (i < 7) ? 2'b10 : 2'b00;
            @(negedge clk);
            drive(2'b11, 2'b10, lk, 3'd0, 3'd7, 16'h0, 16'hC000 + 16'(i));
            #1;
            checks++;
            if (req_ready !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL timeout_ready[%0d]: got=%b want=%b", i, req_ready, exp_seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset while locked with a read response pending clears everything
    task automatic test_reset_mid_lock();
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b10, 3'd0, 3'd6, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rml_lock: got=%b want=10", req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b10, 3'd0, 3'd6, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rml_locked_grant: got=%b want=10", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_data[31:16] !== 16'h1006) begin
            errors++;
            $display("[TB] FAIL rml_rsp: valid=%b data=%h want 10 1006", rsp_valid, rsp_data[31:16]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 2'b00, 2'b10, 3'd0, 3'd6, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b00 || w_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rml_in_reset: ready=%b wen=%b want 00 0", req_ready, w_en);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rml_rsp_suppressed: got=%b want=00", rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 3'd0, 3'd6, 16'h0, 16'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rml_after_reset_grant: got=%b want=01", req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        @(posedge clk); #1;
    endtask

    // Scenario sequence and final summary
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
        test_reset();
        test_write_read();
        test_single_toggle();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
